delay_ram_device: RTL and testbench

DELAY_RAM_DEVICE -- requirements
Module: delay_ram_device

---
 rtl/delay_ram_device_pkg.sv | 23 ++
 rtl/delay_ram_device_if.sv | 22 ++
 rtl/delay_ram_device_resp_queue.sv | 60 ++++++
 rtl/delay_ram_device.sv | 103 ++++++++++
 tb/tb_delay_ram_device.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/delay_ram_device_pkg.sv
// Shared types and parameter bounds for the delayed-grant RAM model.
// Grant FSM states and the response queue entry live here.
package dv_mem_pkg;

  localparam int unsigned GNT_DELAY_MAX       = 7;
  localparam int unsigned RESP_LATENCY_MIN    = 1;
  localparam int unsigned RESP_LATENCY_MAX    = 7;
  localparam int unsigned MAX_OUTSTANDING_MIN = 1;
  localparam int unsigned MAX_OUTSTANDING_MAX = 4;
  localparam int unsigned CD_W                = 3;

  typedef enum logic {
    IDLE,
    STALL
  } gnt_state_t;

  typedef struct packed {
    logic [31:0]     rdata;
    logic            err;
    logic [CD_W-1:0] countdown;
  } resp_entry_t;

endpackage

// File: rtl/delay_ram_device_if.sv
// Request/response bus between a host and the delayed-grant RAM model.
interface delay_ram_device_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/delay_ram_device_resp_queue.sv
// In-order response FIFO; every stored entry counts its latency down each cycle.
module resp_queue
  import dv_mem_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  resp_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output resp_entry_t head
);

  localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CW = $clog2(MaxOutstanding + 1);

  resp_entry_t   entries [MaxOutstanding];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Wrap explicitly so non-power-of-two depths stay lossless.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(MaxOutstanding));
  assign empty = (count == '0);
  assign head  = entries[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (push && (wr_ptr == PW'(i))) begin
        entries[i] <= push_data;
      end else if (entries[i].countdown != '0) begin
        entries[i].countdown <= entries[i].countdown - CD_W'(1);
      end
    end
  end

endmodule

// File: rtl/delay_ram_device.sv
// Word-addressed RAM with programmable grant stall, response latency and
// outstanding-request limit; out-of-range and windowed addresses return errors.
module delay_ram_device
  import dv_mem_pkg::*;
#(
  parameter int unsigned Depth          = 16384,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [31:0] ErrBase        = 32'h0001_F000,
  parameter logic [31:0] ErrMask        = 32'hFFFF_F000
) (
  input logic               clk_i,
  input logic               rst_i,
  delay_ram_device_if.slave bus
);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0) ||
      (GntDelay > GNT_DELAY_MAX) ||
      (RespLatency < RESP_LATENCY_MIN) || (RespLatency > RESP_LATENCY_MAX) ||
      (MaxOutstanding < MAX_OUTSTANDING_MIN) || (MaxOutstanding > MAX_OUTSTANDING_MAX)) begin : g_bad_params
    $fatal(1, "delay_ram_device: parameter out of range");
  end

  localparam int              AW             = $clog2(Depth);
  localparam logic [32:0]     MEM_BYTES      = 33'(Depth) << 2;
  localparam logic [CD_W-1:0] GNT_DELAY_C    = CD_W'(GntDelay);
  localparam logic [CD_W-1:0] RESP_LATENCY_C = CD_W'(RespLatency);

  logic [31:0]     mem [Depth];
  logic [AW-1:0]   word_idx;
  logic            req_err;
  logic            stall_done;
  logic            gnt;
  gnt_state_t      state;
  logic [CD_W-1:0] stall_cnt;
  resp_entry_t     push_entry;
  resp_entry_t     head;
  logic            q_full;
  logic            q_empty;
  logic            rvalid;

  assign word_idx = bus.addr_i[2 +: AW];
  assign req_err  = ({1'b0, bus.addr_i} >= MEM_BYTES) ||
                    ((bus.addr_i & ErrMask) == ErrBase);

  // A full queue blocks the grant even if the head pops this cycle.
  assign stall_done = (GntDelay == 0) ? 1'b1 :
                      ((state == STALL) && (stall_cnt == GNT_DELAY_C));
  assign gnt        = bus.req_i && !q_full && stall_done && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else if (!bus.req_i || gnt || (GntDelay == 0)) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      state     <= STALL;
      stall_cnt <= CD_W'(1);
    end else if (stall_cnt != GNT_DELAY_C) begin
      stall_cnt <= stall_cnt + CD_W'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (gnt && bus.we_i && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) mem[word_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    push_entry           = '0;
    push_entry.err       = req_err;
    push_entry.rdata     = (bus.we_i || req_err) ? 32'h0 : mem[word_idx];
    push_entry.countdown = RESP_LATENCY_C;
  end

  resp_queue #(
    .MaxOutstanding(MaxOutstanding)
  ) u_resp_queue (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (gnt),
    .push_data(push_entry),
    .pop      (rvalid),
    .full     (q_full),
    .empty    (q_empty),
    .head     (head)
  );

  // The head fires in the cycle its countdown expires at the next edge.
  assign rvalid       = !q_empty && (head.countdown <= CD_W'(1));
  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rvalid ? head.rdata : 32'h0;
  assign bus.err_o    = rvalid && head.err;

endmodule

// File: tb/tb_delay_ram_device.sv
// Bench for delay_ram_device: three instances cover zero-stall, stalled-grant
// and long-latency/backpressure configurations against a response scoreboard.
module tb_delay_ram_device;
  import dv_mem_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  int   rv_cnt1 = 0;
  int   rv_cnt2 = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  vec_t vecs [15];

  delay_ram_device_if b0();
  delay_ram_device_if b1();
  delay_ram_device_if b2();

  delay_ram_device #(.GntDelay(0), .RespLatency(1), .MaxOutstanding(2)) dut0 (
    .clk_i(clk), .rst_i(rst0), .bus(b0));
  delay_ram_device #(.GntDelay(3), .RespLatency(1), .MaxOutstanding(2)) dut1 (
    .clk_i(clk), .rst_i(rst1), .bus(b1));
  delay_ram_device #(.GntDelay(0), .RespLatency(4), .MaxOutstanding(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Response monitors: rvalid is expected exactly when the oldest entry is due.
  always begin : mon0
    exp_t e;
    logic exp_rv;
    @(negedge clk); #2;
    exp_rv = (sb0.size() != 0) && (sb0[0].cyc == cyc);
    check("rvalid0", b0.rvalid_o, exp_rv);
    if (exp_rv) begin
      e = sb0.pop_front();
      if (b0.rvalid_o) check("resp0", {b0.rdata_o, b0.err_o}, {e.rdata, e.err});
    end else if (!b0.rvalid_o) begin
      check("idle_zero0", {b0.rdata_o, b0.err_o}, 33'h0);
    end
  end

  always begin : mon1
    exp_t e;
    logic exp_rv;
    @(negedge clk); #2;
    if (b1.rvalid_o) rv_cnt1++;
    exp_rv = (sb1.size() != 0) && (sb1[0].cyc == cyc);
    check("rvalid1", b1.rvalid_o, exp_rv);
    if (exp_rv) begin
      e = sb1.pop_front();
      if (b1.rvalid_o) check("resp1", {b1.rdata_o, b1.err_o}, {e.rdata, e.err});
    end
  end

  always begin : mon2
    exp_t e;
    logic exp_rv;
    @(negedge clk); #2;
    if (b2.rvalid_o) rv_cnt2++;
    exp_rv = (sb2.size() != 0) && (sb2[0].cyc == cyc);
    check("rvalid2", b2.rvalid_o, exp_rv);
    if (exp_rv) begin
      e = sb2.pop_front();
      if (b2.rvalid_o) check("resp2", {b2.rdata_o, b2.err_o}, {e.rdata, e.err});
    end else if (!b2.rvalid_o) begin
      check("idle_zero2", {b2.rdata_o, b2.err_o}, 33'h0);
    end
  end

  task automatic req0(input vec_t v, input int idx);
    int waited = 0;
    @(negedge clk);
    b0.req_i = 1'b1; b0.we_i = v.we; b0.addr_i = v.addr; b0.be_i = v.be; b0.wdata_i = v.wdata;
    #1;
    while (!b0.gnt_o && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (b0.gnt_o) sb0.push_back('{rdata: v.exp_rdata, err: v.exp_err, cyc: cyc + 1});
    check($sformatf("gnt_wait0[%0d]", idx), 64'(waited), 64'd0);
  endtask

  task automatic hold1(input int n, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [15:0] mask);
    mask = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b1.req_i = 1'b1; b1.we_i = 1'b1; b1.addr_i = addr; b1.be_i = 4'hF; b1.wdata_i = wdata;
      #1;
      if (b1.gnt_o) begin
        mask[i] = 1'b1;
        sb1.push_back('{rdata: 32'h0, err: 1'b0, cyc: cyc + 1});
      end
    end
    @(negedge clk);
    b1.req_i = 1'b0;
  endtask

  task automatic hold2(input int n, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       output logic [15:0] mask);
    mask = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b2.req_i = 1'b1; b2.we_i = we; b2.addr_i = addr; b2.be_i = 4'hF; b2.wdata_i = wdata;
      #1;
      if (b2.gnt_o) begin
        mask[i] = 1'b1;
        sb2.push_back('{rdata: exp_rdata, err: 1'b0, cyc: cyc + 4});
      end
    end
    @(negedge clk);
    b2.req_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] mask;
    int          snap;

    vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0040, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0040, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 32'h0002_0000, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h1234_5678, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_F004, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h0001_F004, 4'hF, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 32'h0001_F004, 4'hF, 32'h1111_1111, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h0000_F007, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_FFFC, 4'hF, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h0000_FFFE, 4'hF, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[14] = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,         32'h0,         1'b1};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    b0.req_i = 1'b0; b0.we_i = 1'b0; b0.addr_i = '0; b0.be_i = '0; b0.wdata_i = '0;
    b1.req_i = 1'b0; b1.we_i = 1'b0; b1.addr_i = '0; b1.be_i = '0; b1.wdata_i = '0;
    b2.req_i = 1'b0; b2.we_i = 1'b0; b2.addr_i = '0; b2.be_i = '0; b2.wdata_i = '0;
    repeat (2) @(negedge clk);
    b0.req_i = 1'b1; b1.req_i = 1'b1;
    #1;
    check("rst_gnt0", b0.gnt_o, 1'b0);
    check("rst_gnt1", b1.gnt_o, 1'b0);
    check("rst_out0", {b0.rvalid_o, b0.rdata_o, b0.err_o}, 34'h0);
    b0.req_i = 1'b0; b1.req_i = 1'b0;
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Zero-stall instance: table of reads/writes, masks and error addresses.
    for (int i = 0; i < 15; i++) req0(vecs[i], i);
    @(negedge clk);
    b0.req_i = 1'b0;

    // Stalled grant: fourth cycle of a held request, abort, back-to-back.
    hold1(5, 32'h100, 32'h0000_0001, mask);
    check("stall_hold5", mask, 16'h0008);
    snap = rv_cnt1;
    hold1(2, 32'h104, 32'h0000_0002, mask);
    check("stall_abort", mask, 16'h0000);
    repeat (6) @(negedge clk);
    check("stall_abort_rvalid", 64'(rv_cnt1 - snap), 64'd0);
    hold1(8, 32'h108, 32'h0000_0003, mask);
    check("stall_b2b", mask, 16'h0088);

    // Long latency with two outstanding slots.
    hold2(1, 1'b1, 32'h80, 32'h0BAD_CAFE, 32'h0, mask);
    check("lat_wr", mask, 16'h0001);
    repeat (6) @(negedge clk);
    hold2(6, 1'b0, 32'h80, 32'h0, 32'h0BAD_CAFE, mask);
    check("backpressure", mask, 16'h0023);
    repeat (8) @(negedge clk);

    // Reset between a grant and its response.
    hold2(1, 1'b0, 32'h80, 32'h0, 32'h0BAD_CAFE, mask);
    check("pre_rst_gnt", mask, 16'h0001);
    rst2 = 1'b1;
    b2.req_i = 1'b1;
    sb2.delete();
    snap = rv_cnt2;
    #1;
    check("mid_rst_gnt", b2.gnt_o, 1'b0);
    check("mid_rst_rvalid", b2.rvalid_o, 1'b0);
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    b2.req_i = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_discard", 64'(rv_cnt2 - snap), 64'd0);
    hold2(1, 1'b0, 32'h80, 32'h0, 32'h0BAD_CAFE, mask);
    check("post_rst_gnt", mask, 16'h0001);

    repeat (10) @(negedge clk);
    check("drain0", 64'(sb0.size()), 64'd0);
    check("drain1", 64'(sb1.size()), 64'd0);
    check("drain2", 64'(sb2.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
